// File: rtl/led_pwm_bank.sv
// led_pwm_bank: bank of NUM_LEDS PWM channels sharing one prescaler and one
// period counter. Each channel has a host-written pending duty and an active
// duty. Pending is copied to active only at period boundaries, so a duty
// change never cuts or stretches a pulse part-way through a period.
module led_pwm_bank #(
    parameter int NUM_LEDS = 8,
    parameter int DUTY_W   = 7,
    parameter int ADDR_W   = 4,
    parameter int PRESCALE = 64
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [DUTY_W-1:0]   i_wr_duty,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [DUTY_W-1:0]   o_rd_duty,
    output logic                o_wr_err,
    output logic                o_period_start,
    output logic [NUM_LEDS-1:0] o_pwm
);

    // The prescaler needs at least one bit, even when PRESCALE is 1.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
    // Period counter runs 0 .. 2^DUTY_W-2, so duty 2^DUTY_W-1 is always on.
    localparam logic [DUTY_W-1:0] CNT_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};

    logic [PS_W-1:0]     presc_p0;
    logic                tick_p0;
    logic [DUTY_W-1:0]   pwm_cnt_p0;
    logic                wrap_p0;

    logic [DUTY_W-1:0]   pending [NUM_LEDS];
    logic [DUTY_W-1:0]   active  [NUM_LEDS];

    logic [NUM_LEDS-1:0] wr_sel;
    logic                wr_hit;
    logic [DUTY_W-1:0]   rd_val;

    // ---- stage p0: timebase (prescaler tick and period counter) ----
    assign tick_p0 = (presc_p0 == PS_LAST);
    assign wrap_p0 = tick_p0 && (pwm_cnt_p0 == CNT_LAST);

    // Prescaler: counts sysclk cycles per PWM tick and wraps on the tick.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            presc_p0 <= '0;
        end else if (tick_p0) begin
            presc_p0 <= '0;
        end else begin
            presc_p0 <= presc_p0 + 1'b1;
        end
    end

    // Period counter: advances once per tick and wraps at the period end.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_p0 <= '0;
        end else if (tick_p0) begin
            if (wrap_p0) begin
                pwm_cnt_p0 <= '0;
            end else begin
                pwm_cnt_p0 <= pwm_cnt_p0 + 1'b1;
            end
        end
    end

    // Address decode for writes and readback; out-of-range addresses match
    // no channel, which flags the write error and reads back as zero.
    always_comb begin
        wr_sel = '0;
        wr_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (i_wr_addr == ADDR_W'(i)) begin
                wr_sel[i] = 1'b1;
                wr_hit    = 1'b1;
            end
            if (i_rd_addr == ADDR_W'(i)) begin
                rd_val = pending[i];
            end
        end
    end

    // Duty bank: host writes land in pending; active takes pending's
    // pre-write value at the boundary, so a write on the boundary edge
    // waits one more period.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (i_wr_en && wr_sel[i]) begin
                    pending[i] <= i_wr_duty;
                end
                if (wrap_p0) begin
                    active[i] <= pending[i];
                end
            end
        end
    end

    // ---- stage p1: registered outputs ----
    // Compare, readback, error and boundary flags registered onto the pins.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            o_pwm          <= '0;
            o_rd_duty      <= '0;
            o_wr_err       <= 1'b0;
            o_period_start <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                o_pwm[i] <= (pwm_cnt_p0 < active[i]);
            end
            o_rd_duty      <= rd_val;
            o_wr_err       <= i_wr_en && !wr_hit;
            o_period_start <= wrap_p0;
        end
    end

endmodule
